// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled serial line in, word plus
// parity/framing/overrun status out through a valid/ack handshake.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rx,
  input  logic                 i_ack,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Non-zero when the received parity bit does not match the configured sense.
  function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
    return (^d) ^ p ^ 1'(PARITY_ODD);
  endfunction

  logic [1:0]           sync_r;
  logic                 rx_s;
  state_t               state_r, state_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic [IW-1:0]        idx_r, idx_s;
  logic                 stop_idx_r, stop_idx_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 par_err_r, par_err_s;
  logic                 frm_err_r, frm_err_s;
  logic                 commit_r, commit_s;

  assign rx_s = sync_r[1];

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], i_rx};
    end
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      idx_r      <= '0;
      stop_idx_r <= 1'b0;
      shift_r    <= '0;
      par_err_r  <= 1'b0;
      frm_err_r  <= 1'b0;
      commit_r   <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      idx_r      <= idx_s;
      stop_idx_r <= stop_idx_s;
      shift_r    <= shift_s;
      par_err_r  <= par_err_s;
      frm_err_r  <= frm_err_s;
      commit_r   <= commit_s;
      o_busy     <= (state_s != IDLE);
    end
  end

  // Next-state logic: the FSM only moves on oversample ticks.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    idx_s      = idx_r;
    stop_idx_s = stop_idx_r;
    shift_s    = shift_r;
    par_err_s  = par_err_r;
    frm_err_s  = frm_err_r;
    commit_s   = 1'b0;
    if (i_tick) begin
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_s   = START;
            cnt_s     = '0;
            par_err_s = 1'b0;
            frm_err_s = 1'b0;
          end else begin
            state_s = IDLE;
          end
        end
        START: begin
          if (cnt_r == HALF_M1) begin
            cnt_s = '0;
            idx_s = '0;
            // A line that is high again at mid start bit was only a glitch.
            if (!rx_s) begin
              state_s = DATA;
            end else begin
              state_s = IDLE;
            end
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        DATA: begin
          if (cnt_r == FULL_M1) begin
            cnt_s          = '0;
            shift_s[idx_r] = rx_s;
            if (idx_r == LAST_BIT) begin
              stop_idx_s = 1'b0;
              if (PARITY_EN != 0) begin
                state_s = PARITY;
              end else begin
                state_s = STOP;
              end
            end else begin
              idx_s = idx_r + IW'(1);
            end
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        PARITY: begin
          if (cnt_r == FULL_M1) begin
            cnt_s      = '0;
            par_err_s  = parity_error(shift_r, rx_s);
            stop_idx_s = 1'b0;
            state_s    = STOP;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        STOP: begin
          if (cnt_r == FULL_M1) begin
            cnt_s = '0;
            if (!rx_s) begin
              frm_err_s = 1'b1;
            end else begin
              frm_err_s = frm_err_r;
            end
            // Back to IDLE at mid stop bit so an early next start bit is caught.
            if (stop_idx_r == LAST_STOP) begin
              commit_s = 1'b1;
              state_s  = IDLE;
            end else begin
              stop_idx_s = stop_idx_r + 1'b1;
            end
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Output word and status handshake; a commit takes priority over an ack.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else if (commit_r) begin
      o_data       <= shift_r;
      o_parity_err <= par_err_r;
      o_frame_err  <= frm_err_r;
      o_valid      <= 1'b1;
      if (o_valid && !i_ack) begin
        o_overrun <= 1'b1;
      end else if (i_ack) begin
        o_overrun <= 1'b0;
      end else begin
        o_overrun <= o_overrun;
      end
    end else if (o_valid && i_ack) begin
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_valid <= o_valid;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1/16x, 8E2/8x, 5N1/16x)
// driven with directed vectors, corner sequences and random frames.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [2:0] rx;
  logic [2:0] ack;
  logic [2:0] valid, perr, ferr, ovr, busy;
  logic [7:0] data0, data1;
  logic [4:0] data2;

  int checks = 0;
  int failures = 0;
  bit pending [3];

  always #5 clk = ~clk;

  // One-cycle tick every third clock, changed on the falling edge.
  initial begin
    int c;
    c = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (c == 2);
      c = (c == 2) ? 0 : c + 1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  uart_rx_param u0 (
    .i_clock(clk), .i_reset(rst_n), .i_tick(tick), .i_rx(rx[0]), .i_ack(ack[0]),
    .o_data(data0), .o_valid(valid[0]), .o_parity_err(perr[0]),
    .o_frame_err(ferr[0]), .o_overrun(ovr[0]), .o_busy(busy[0])
  );

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
    .i_clock(clk), .i_reset(rst_n), .i_tick(tick), .i_rx(rx[1]), .i_ack(ack[1]),
    .o_data(data1), .o_valid(valid[1]), .o_parity_err(perr[1]),
    .o_frame_err(ferr[1]), .o_overrun(ovr[1]), .o_busy(busy[1])
  );

  uart_rx_param #(.DATA_BITS(5)) u2 (
    .i_clock(clk), .i_reset(rst_n), .i_tick(tick), .i_rx(rx[2]), .i_ack(ack[2]),
    .o_data(data2), .o_valid(valid[2]), .o_parity_err(perr[2]),
    .o_frame_err(ferr[2]), .o_overrun(ovr[2]), .o_busy(busy[2])
  );

  function automatic int f_os(input int i);
    case (i)
      1: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int f_db(input int i);
    case (i)
      2: return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int f_pe(input int i);
    case (i)
      1: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int f_sb(input int i);
    case (i)
      1: return 2;
      default: return 1;
    endcase
  endfunction

  // Tick (counted from the tick at which the line falls) of the last stop sample.
  function automatic int last_sample(input int i);
    return 1 + f_os(i) / 2 + f_os(i) * (f_db(i) + f_pe(i) + f_sb(i));
  endfunction

  function automatic int frame_ticks(input int i);
    return (1 + f_db(i) + f_pe(i) + f_sb(i) + 2) * f_os(i);
  endfunction

  function automatic logic [31:0] get_data(input int i);
    case (i)
      0: return 32'(data0);
      1: return 32'(data1);
      default: return 32'(data2);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_tick();
    @(posedge clk);
    while (tick !== 1'b1) @(posedge clk);
    #1;
  endtask

  // Drive one frame (line held high after the last bit) for n_ticks ticks.
  // Caller must be positioned just after a tick edge.
  task automatic send_frame(input int idx, input logic [8:0] d, input logic pbit,
                            input logic [1:0] stop, input int n_ticks,
                            input int ack_at, input bit lat);
    int os, db, pe, sb, nb, ls;
    logic [15:0] bits;
    os = f_os(idx); db = f_db(idx); pe = f_pe(idx); sb = f_sb(idx);
    nb = 1 + db + pe + sb;
    ls = last_sample(idx);
    bits = '1;
    bits[0] = 1'b0;
    for (int k = 0; k < db; k++) bits[1 + k] = d[k];
    if (pe != 0) bits[1 + db] = pbit;
    for (int k = 0; k < sb; k++) bits[1 + db + pe + k] = stop[k];
    for (int t = 0; t < n_ticks; t++) begin
      int e;
      e = t / os;
      rx[idx] = (e < nb) ? bits[e] : 1'b1;
      if (lat && t == ls - 1) chk("latency_early_valid", 32'(valid[idx]), 32'd0);
      if (lat && t == ls + 2) chk("latency_late_valid", 32'(valid[idx]), 32'd1);
      if (t == ack_at) begin
        ack[idx] = 1'b1;
        @(posedge clk);
        #1;
        ack[idx] = 1'b0;
      end
      next_tick();
    end
  endtask

  task automatic check_word(input int idx, input logic [8:0] d, input logic p,
                            input logic f, input logic o);
    chk($sformatf("valid[%0d]", idx), 32'(valid[idx]), 32'd1);
    chk($sformatf("data[%0d]", idx), get_data(idx), 32'(d));
    chk($sformatf("parity_err[%0d]", idx), 32'(perr[idx]), 32'(p));
    chk($sformatf("frame_err[%0d]", idx), 32'(ferr[idx]), 32'(f));
    chk($sformatf("overrun[%0d]", idx), 32'(ovr[idx]), 32'(o));
  endtask

  task automatic ack_clear(input int idx);
    ack[idx] = 1'b1;
    @(posedge clk);
    #1;
    ack[idx] = 1'b0;
    chk($sformatf("ack_valid[%0d]", idx), 32'(valid[idx]), 32'd0);
    chk($sformatf("ack_flags[%0d]", idx), 32'({perr[idx], ferr[idx], ovr[idx]}), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_outs[%0d]", tag, i),
          32'({valid[i], perr[i], ferr[i], ovr[i], busy[i]}), 32'd0);
      chk($sformatf("%s_data[%0d]", tag, i), get_data(i), 32'd0);
    end
  endtask

  typedef struct {
    int         idx;
    logic [8:0] d;
    logic       pbit;
    logic [1:0] stop;
    logic [8:0] exp_d;
    logic       exp_p;
    logic       exp_f;
  } vec_t;

  initial begin
    vec_t vecs [7];
    vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{1, 9'h007, 1'b0, 2'b11, 9'h007, 1'b1, 1'b0};
    vecs[2] = '{1, 9'h007, 1'b1, 2'b11, 9'h007, 1'b0, 1'b0};
    vecs[3] = '{0, 9'h03C, 1'b0, 2'b10, 9'h03C, 1'b0, 1'b1};
    vecs[4] = '{1, 9'h05A, 1'b0, 2'b01, 9'h05A, 1'b0, 1'b1};
    vecs[5] = '{2, 9'h03B, 1'b0, 2'b11, 9'h01B, 1'b0, 1'b0};
    vecs[6] = '{1, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};

    rst_n = 1'b0;
    rx = 3'b111;
    ack = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) next_tick();

    // Directed vectors.
    for (int v = 0; v < 7; v++) begin
      next_tick();
      send_frame(vecs[v].idx, vecs[v].d, vecs[v].pbit, vecs[v].stop,
                 frame_ticks(vecs[v].idx), -1, 1'b1);
      check_word(vecs[v].idx, vecs[v].exp_d, vecs[v].exp_p, vecs[v].exp_f, 1'b0);
      ack_clear(vecs[v].idx);
    end

    // Short low glitch: no word, receiver back to idle.
    next_tick();
    for (int t = 0; t < 16; t++) begin
      rx[0] = (t < 4) ? 1'b0 : 1'b1;
      if (t == 3) chk("glitch_busy_high", 32'(busy[0]), 32'd1);
      if (t == 11) chk("glitch_busy_low", 32'(busy[0]), 32'd0);
      next_tick();
    end
    chk("glitch_no_valid", 32'(valid[0]), 32'd0);

    // Overrun, then an ack landing exactly on the commit cycle.
    next_tick();
    send_frame(0, 9'h011, 1'b0, 2'b11, frame_ticks(0), -1, 1'b1);
    check_word(0, 9'h011, 1'b0, 1'b0, 1'b0);
    next_tick();
    send_frame(0, 9'h022, 1'b0, 2'b11, frame_ticks(0), -1, 1'b0);
    check_word(0, 9'h022, 1'b0, 1'b0, 1'b1);
    next_tick();
    send_frame(0, 9'h033, 1'b0, 2'b11, frame_ticks(0), last_sample(0), 1'b0);
    check_word(0, 9'h033, 1'b0, 1'b0, 1'b0);
    ack_clear(0);

    // Random frames against the reference model.
    for (int r = 0; r < 24; r++) begin
      int idx, db, sb, pe;
      logic [8:0] d;
      logic pbit, exp_p, exp_f;
      logic [1:0] stop;
      idx = r % 2;
      db = f_db(idx); sb = f_sb(idx); pe = f_pe(idx);
      d = 9'($urandom) & ((9'd1 << db) - 9'd1);
      pbit = 1'($urandom_range(0, 1));
      stop[0] = ($urandom_range(0, 5) != 0);
      stop[1] = ($urandom_range(0, 5) != 0);
      exp_p = (pe != 0) && ((($countones(d) + int'(pbit)) % 2) != 0);
      exp_f = (stop[0] == 1'b0) || (sb == 2 && stop[1] == 1'b0);
      next_tick();
      send_frame(idx, d, pbit, stop, frame_ticks(idx), -1, !pending[idx]);
      check_word(idx, d, exp_p, exp_f, pending[idx]);
      if ($urandom_range(0, 1) == 1) begin
        ack_clear(idx);
        pending[idx] = 1'b0;
      end else begin
        pending[idx] = 1'b1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (pending[i]) begin
        ack_clear(i);
        pending[i] = 1'b0;
      end
    end

    // 5-bit frames back to back (next start mid stop bit), then reset mid-frame.
    next_tick();
    send_frame(2, 9'h01F, 1'b0, 2'b11, 16 * 6 + 10, -1, 1'b1);
    send_frame(2, 9'h00A, 1'b0, 2'b11, 16 * 4 + 8, -1, 1'b0);
    check_word(2, 9'h01F, 1'b0, 1'b0, 1'b0);
    chk("b2b_busy", 32'(busy[2]), 32'd1);
    rst_n = 1'b0;
    #3;
    check_all_zero("midreset");
    rx[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) next_tick();
    check_all_zero("postreset");
    next_tick();
    send_frame(2, 9'h015, 1'b0, 2'b11, frame_ticks(2), -1, 1'b1);
    check_word(2, 9'h015, 1'b0, 1'b0, 1'b0);
    ack_clear(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
